// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   DEF_DATA_W / DEF_NUM_REGS : default geometry (16-bit x 8 registers)
//   rd_src_e                  : where a read port takes its data from
//   wr0_keep()                : write-port priority resolve (port 1 beats port 0)
//   rd_src()                  : read-source select for one read port
package regfile_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;

  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_WR0  = 2'd1,
    SRC_WR1  = 2'd2,
    SRC_ZERO = 2'd3
  } rd_src_e;

  // Port 0 is dropped when port 1 writes the same register in the same cycle.
  function automatic logic wr0_keep(input logic wr0_en, input logic wr1_en,
                                    input logic same_addr);
    return wr0_en && !(wr1_en && same_addr);
  endfunction

  // Hardwired zero beats everything, then the load path, then the ALU path.
  function automatic rd_src_e rd_src(input logic is_zero, input logic hit1,
                                     input logic hit0);
    if (is_zero)   return SRC_ZERO;
    else if (hit1) return SRC_WR1;
    else if (hit0) return SRC_WR0;
    else           return SRC_REG;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback and the register file.
//   wr0_*        : ALU writeback port
//   wr1_*        : load writeback port (priority over wr0)
//   rd_addr/data : NUM_RD packed read ports, port k at slice k
//   rd_busy      : scoreboard busy flag per read port
//   sb_*         : scoreboard set / flush from decode
//   busy_any     : OR of all busy bits
// master drives writes, reads and scoreboard requests; slave is the regfile.
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = $clog2(DEF_NUM_REGS),
  parameter int NUM_RD = 2
);
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     sb_set_en;
  logic [ADDR_W-1:0]        sb_set_addr;
  logic                     sb_flush;
  logic                     busy_any;

  modport master (
    output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    output rd_addr, sb_set_en, sb_set_addr, sb_flush,
    input  rd_data, rd_busy, busy_any
  );

  modport slave (
    input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    input  rd_addr, sb_set_en, sb_set_addr, sb_flush,
    output rd_data, rd_busy, busy_any
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for hazard detection.
//   clk, rst           : clock, synchronous active-high reset
//   clr0_*/clr1_*      : writeback ports; a write clears that register's busy bit
//   set_en/set_addr    : destination issued, mark busy (wins over a clear)
//   flush              : clear every busy bit (wins over set)
//   rd_addr, byp_hit   : per read port address and "data is being bypassed" flag
//   rd_busy, busy_any  : per-port busy lookup, OR of the registered busy vector
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr0_en,
  input  logic [ADDR_W-1:0]        clr0_addr,
  input  logic                     clr1_en,
  input  logic [ADDR_W-1:0]        clr1_addr,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        byp_hit,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     busy_any
);
  localparam bit ZR = (ZERO_REG != 0);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [ADDR_W-1:0]   ra;

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (clr0_en && (clr0_addr == ADDR_W'(i))) busy_d[i] = 1'b0;
      if (clr1_en && (clr1_addr == ADDR_W'(i))) busy_d[i] = 1'b0;
      // A new producer issuing while the old one writes back keeps the bit set.
      if (set_en && (set_addr == ADDR_W'(i)))   busy_d[i] = 1'b1;
    end
    if (flush) busy_d = '0;
    if (ZR)    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // When a read is served from a writeback port, the old busy bit is stale:
  // only a same-cycle re-issue to that register can keep it busy.
  always_comb begin
    rd_busy = '0;
    ra      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      if (ZR && (ra == '0))
        rd_busy[k] = 1'b0;
      else if (byp_hit[k])
        rd_busy[k] = set_en && !flush && (set_addr == ra);
      else
        rd_busy[k] = busy_q[ra];
    end
  end

  assign busy_any = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with two write ports, optional
// write-to-read bypass, optional hardwired-zero r0 and a busy scoreboard.
//   clk, rst : clock, synchronous active-high reset (clears data and busy)
//   bus      : regfile_mp_if slave modport (write ports, read ports,
//              scoreboard set/flush, rd_busy, busy_any)
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [DATA_W-1:0]        mem [NUM_REGS];
  logic                     wr0_we;
  logic                     wr1_we;
  logic [NUM_RD*DATA_W-1:0] rd_data_w;
  logic [NUM_RD-1:0]        byp_hit;
  logic [ADDR_W-1:0]        ra;
  logic                     hit0;
  logic                     hit1;
  logic                     is_zero;

  assign wr1_we = bus.wr1_en && !(ZR && (bus.wr1_addr == '0));
  assign wr0_we = wr0_keep(bus.wr0_en && !(ZR && (bus.wr0_addr == '0)),
                           wr1_we, bus.wr0_addr == bus.wr1_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else begin
      if (wr0_we) mem[bus.wr0_addr] <= bus.wr0_data;
      if (wr1_we) mem[bus.wr1_addr] <= bus.wr1_data;
    end
  end

  always_comb begin
    rd_data_w = '0;
    byp_hit   = '0;
    ra        = '0;
    hit0      = 1'b0;
    hit1      = 1'b0;
    is_zero   = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra      = bus.rd_addr[k*ADDR_W +: ADDR_W];
      is_zero = ZR && (ra == '0);
      hit1    = BP && bus.wr1_en && (bus.wr1_addr == ra);
      hit0    = BP && bus.wr0_en && (bus.wr0_addr == ra);
      case (rd_src(is_zero, hit1, hit0))
        SRC_ZERO: rd_data_w[k*DATA_W +: DATA_W] = '0;
        SRC_WR1:  rd_data_w[k*DATA_W +: DATA_W] = bus.wr1_data;
        SRC_WR0:  rd_data_w[k*DATA_W +: DATA_W] = bus.wr0_data;
        default:  rd_data_w[k*DATA_W +: DATA_W] = mem[ra];
      endcase
      byp_hit[k] = hit0 || hit1;
    end
  end

  assign bus.rd_data = rd_data_w;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .clr0_en   (bus.wr0_en),
    .clr0_addr (bus.wr0_addr),
    .clr1_en   (bus.wr1_en),
    .clr1_addr (bus.wr1_addr),
    .set_en    (bus.sb_set_en),
    .set_addr  (bus.sb_set_addr),
    .flush     (bus.sb_flush),
    .rd_addr   (bus.rd_addr),
    .byp_hit   (byp_hit),
    .rd_busy   (bus.rd_busy),
    .busy_any  (bus.busy_any)
  );

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor to the team's 8x16 two-read/one-write register file.
- Adds: configurable width, depth and read-port count; a second write port for the load/ALU writeback paths; optional write-to-read bypass; optional hardwired-zero register 0; a per-register busy scoreboard for hazard detection.
- Sits between decode (read addresses, scoreboard set) and writeback (two write ports) in the MIPS datapath.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, number of registers; must be a power of 2 and at least 2.
- ADDR_W, $clog2(NUM_REGS), address width; derived, do not override.
- NUM_RD, 2, number of read ports; range 1..4.
- ZERO_REG, 0, when 1, register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1, same-cycle write data is forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr0_en  in  1  write port 0 enable (ALU writeback).
- wr0_addr  in  ADDR_W  write port 0 address.
- wr0_data  in  DATA_W  write port 0 data.
- wr1_en  in  1  write port 1 enable (load writeback); has priority over port 0.
- wr1_addr  in  ADDR_W  write port 1 address.
- wr1_data  in  DATA_W  write port 1 data.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k is at slice [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port k is at slice [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  scoreboard busy flag for each read address.
- sb_set_en  in  1  mark register sb_set_addr busy (destination issued).
- sb_set_addr  in  ADDR_W  scoreboard set address.
- sb_flush  in  1  clear all busy bits (pipeline flush).
- busy_any  out  1  OR of all busy bits (registered state).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at a rising edge, all registers clear to 0 and all busy bits clear to 0. rst overrides every other input that cycle.
- Outputs after reset: rd_data=0 for every address, rd_busy=0, busy_any=0.
- Writes: on a rising edge with wrN_en=1, reg[wrN_addr] <= wrN_data.
  - Both ports enabled to the same address: port 1 wins, port 0 is dropped.
  - Different addresses: both writes land in the same edge.
- Writes clear busy: a write on either port clears busy[addr] at the same edge.
- Scoreboard set: sb_set_en=1 sets busy[sb_set_addr].
  - Set and write-clear to the same register in one cycle: set wins, busy stays 1. This covers a new producer issuing while the old one writes back.
- Flush: sb_flush=1 clears every busy bit, overriding sb_set_en that cycle. Register contents are unaffected.
- ZERO_REG=1: writes to address 0 are ignored, sb_set to address 0 is ignored, reads of address 0 return 0 with busy 0, and no bypass applies to address 0.
- Reads are combinational, with zero-cycle latency from rd_addr.
  - BYPASS=0: rd_data = reg[addr] (pre-edge state); rd_busy = busy[addr].
  - BYPASS=1: if wr1_en and wr1_addr matches, return wr1_data; else if wr0_en and wr0_addr matches, return wr0_data; else return reg[addr]. On a bypass hit, rd_busy = (sb_set_en & ~sb_flush & sb_set_addr==addr); otherwise rd_busy = busy[addr].
- Read ports are independent; any number may name the same address.
- Out-of-range addresses cannot occur because NUM_REGS = 2^ADDR_W.

Decomposition:
- Shared package regfile_pkg holds the default DATA_W and NUM_REGS and a function for the write-priority resolve.
- Natural sub-module: regfile_scoreboard, holding the busy-bit vector with set, clear, flush, busy_any and the per-port rd_busy lookup. The top level holds the storage array and the read/bypass muxes.

Test Plan:
- Reset: write r3=0x1234, assert rst for 1 cycle -> all reads of r0..r7 return 0x0000, rd_busy=0, busy_any=0.
- Dual write: wr0 r2=0xAAAA and wr1 r5=0x5555 in one cycle -> next cycle r2=0xAAAA, r5=0x5555. Then wr0 r4=0x1111 and wr1 r4=0x2222 -> r4=0x2222.
- Bypass (BYPASS=1): rd_addr[0]=6 while wr0 r6=0xBEEF -> rd_data[0]=0xBEEF in the same cycle. With BYPASS=0 -> the old value in that cycle, 0xBEEF the next cycle.
- Scoreboard: sb_set r1 -> rd_busy=1 and busy_any=1 the next cycle. wr0 r1=0x0042 together with sb_set r1 -> busy stays 1. Later wr1 r1 alone -> busy clears to 0. sb_flush with sb_set r7 -> busy_any=0.
- ZERO_REG=1: wr1 r0=0xFFFF plus sb_set r0 -> r0 reads 0x0000, rd_busy=0, including in the same-cycle bypass case.
- Parametrisation: DATA_W=32, NUM_REGS=32, NUM_RD=3 -> write 0xDEADBEEF to r31, then three ports reading r31, r0 and r31 return correct independent values.
